// File: rtl/lstm_gate_mac.sv
// LSTM gate pre-activation engine: z[r] = sum_k W[r][k]*v[k] + b[r] on one sequential 32x32 multiplier.
// Build option LSTM_GATE_MAC_SAT_EN: clamp out_data to the signed 32-bit range instead of wrapping.
module lstm_gate_mac #(
    parameter int unsigned IN_LEN    = 100,
    parameter int unsigned HID       = 100,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned WADDR_W   = 17
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic signed [31:0]        i_in_data,
    output logic                      o_w_rd_en,
    output logic        [WADDR_W-1:0] o_w_addr,
    input  logic signed [31:0]        i_w_rd_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic signed [31:0]        o_out_data,
    output logic        [8:0]         o_out_idx,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned K       = IN_LEN + HID;
    localparam int unsigned OUT_LEN = 4 * HID;
    localparam int unsigned KW      = $clog2(K + 1);
    localparam int unsigned KIW     = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned ACC_W   = 64 + $clog2(K + 1);
    localparam int unsigned RW      = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    state_t                    r_state;
    logic        [KIW-1:0]     r_ld_k;
    logic        [KW-1:0]      r_rd_k;
    logic                      r_pend;
    logic        [KW-1:0]      r_pend_k;
    logic signed [ACC_W-1:0]   r_acc;
    logic        [RW-1:0]      r_row;
    logic signed [31:0]        r_vbuf [0:K-1];

    logic signed [31:0]        w_vk;
    logic signed [63:0]        w_prod;
    logic signed [ACC_W-1:0]   w_bias_term;
    logic signed [ACC_W-1:0]   w_addend;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic        [31:0]        w_res;
    logic                      w_accept;
    logic                      w_is_bias;

    assign w_accept  = (r_state == S_IDLE || r_state == S_LOAD) && i_in_valid && o_in_ready;
    assign w_is_bias = (r_pend_k == KW'(K));

    // Operand path for the word returned by the memory this cycle.
    assign w_vk        = (r_pend_k < KW'(K)) ? r_vbuf[r_pend_k[KIW-1:0]] : '0;
    assign w_prod      = 64'(i_w_rd_data) * 64'(w_vk);
    assign w_bias_term = ACC_W'(i_w_rd_data) <<< FRAC_BITS;
    assign w_addend    = w_is_bias ? w_bias_term : ACC_W'(w_prod);
    assign w_acc_nxt   = r_acc + w_addend;

`ifdef LSTM_GATE_MAC_SAT_EN
    logic signed [ACC_W-1:0]   w_shift;
    logic                      w_pos_ovf;
    logic                      w_neg_ovf;

    // Out of range whenever the bits above bit 31 are not pure sign copies.
    assign w_shift   = w_acc_nxt >>> FRAC_BITS;
    assign w_pos_ovf = !w_shift[ACC_W-1] && (|w_shift[ACC_W-2:31]);
    assign w_neg_ovf =  w_shift[ACC_W-1] && !(&w_shift[ACC_W-2:31]);
    assign w_res     = w_pos_ovf ? 32'h7FFF_FFFF :
                       w_neg_ovf ? 32'h8000_0000 : w_shift[31:0];
`else
    assign w_res     = w_acc_nxt[FRAC_BITS +: 32];
`endif

    // Vector buffer holds data only; validity is tracked by the control FSM.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_vbuf[r_ld_k] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ld_k      <= '0;
            r_rd_k      <= '0;
            r_pend      <= 1'b0;
            r_pend_k    <= '0;
            r_acc       <= '0;
            r_row       <= '0;
            o_in_ready  <= 1'b0;
            o_w_rd_en   <= 1'b0;
            o_w_addr    <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_idx   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            r_pend   <= o_w_rd_en;
            r_pend_k <= r_rd_k;

            case (r_state)
                S_IDLE, S_LOAD: begin
                    o_in_ready <= 1'b1;
                    if (w_accept) begin
                        o_busy <= 1'b1;
                        if (r_ld_k == KIW'(K - 1)) begin
                            r_state    <= S_MAC;
                            o_in_ready <= 1'b0;
                            r_ld_k     <= '0;
                            r_row      <= '0;
                            r_acc      <= '0;
                            r_rd_k     <= '0;
                            o_w_addr   <= '0;
                            o_w_rd_en  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_ld_k  <= r_ld_k + KIW'(1);
                        end
                    end
                end

                S_MAC: begin
                    // Read issue: K weights then the bias, one address per cycle.
                    if (o_w_rd_en) begin
                        if (r_rd_k == KW'(K)) begin
                            o_w_rd_en <= 1'b0;
                        end else begin
                            o_w_addr <= o_w_addr + WADDR_W'(1);
                            r_rd_k   <= r_rd_k + KW'(1);
                        end
                    end
                    // Accumulate the word that arrives one cycle behind its read.
                    if (r_pend) begin
                        r_acc <= w_acc_nxt;
                        if (w_is_bias) begin
                            o_out_valid <= 1'b1;
                            o_out_data  <= w_res;
                            o_out_idx   <= r_row;
                            r_state     <= S_OUT;
                        end
                    end
                end

                S_OUT: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        r_acc       <= '0;
                        if (r_row == RW'(OUT_LEN - 1)) begin
                            r_state    <= S_IDLE;
                            o_done     <= 1'b1;
                            o_busy     <= 1'b0;
                            o_in_ready <= 1'b1;
                            o_w_addr   <= '0;
                        end else begin
                            r_state   <= S_MAC;
                            r_row     <= r_row + RW'(1);
                            r_rd_k    <= '0;
                            o_w_addr  <= o_w_addr + WADDR_W'(1);
                            o_w_rd_en <= 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Self-checking bench for lstm_gate_mac (IN_LEN=2, HID=2) with a weight memory model and arithmetic reference.
module tb_lstm_gate_mac;

    localparam int unsigned IN_LEN  = 2;
    localparam int unsigned HID     = 2;
    localparam int unsigned K       = IN_LEN + HID;
    localparam int unsigned OUT_LEN = 4 * HID;
    localparam int unsigned FRAC    = 16;
    localparam int unsigned WADDR_W = 6;
    localparam int unsigned NW      = OUT_LEN * (K + 1);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic signed [31:0]        in_data = '0;
    logic                      w_rd_en;
    logic        [WADDR_W-1:0] w_addr;
    logic signed [31:0]        w_rd_data;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic signed [31:0]        out_data;
    logic        [8:0]         out_idx;
    logic                      busy;
    logic                      done;

    int errors = 0;
    int checks = 0;

    logic signed [31:0] wmem [0:63];
    logic signed [31:0] vvec [0:K-1];

    logic [31:0]        g_data [OUT_LEN];
    logic [8:0]         g_idx  [OUT_LEN];
    int                 g_cyc  [OUT_LEN];
    int                 g_bias [OUT_LEN];
    int                 g_rise [OUT_LEN];
    logic               g_en   [OUT_LEN];
    logic [WADDR_W-1:0] g_addr [OUT_LEN];
    int                 done_early;
    logic               done_end;
    bit                 timed_out;

    always #5 clk = ~clk;

    lstm_gate_mac #(
        .IN_LEN   (IN_LEN),
        .HID      (HID),
        .FRAC_BITS(FRAC),
        .WADDR_W  (WADDR_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .o_w_rd_en  (w_rd_en),
        .o_w_addr   (w_addr),
        .i_w_rd_data(w_rd_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_out_idx  (out_idx),
        .o_busy     (busy),
        .o_done     (done)
    );

    // Synchronous weight memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wmem[w_addr];
    end

    function automatic logic [31:0] ref_z(input int r);
        logic signed [79:0] s;
        logic signed [79:0] sh;
        s = '0;
        for (int k = 0; k < K; k++)
            s = s + 80'(wmem[r*(K+1)+k]) * 80'(vvec[k]);
        s  = s + 80'(wmem[r*(K+1)+K]) * 80'sd65536;
        sh = s >>> FRAC;
`ifdef LSTM_GATE_MAC_SAT_EN
        if (sh > 80'sd2147483647)  return 32'h7FFF_FFFF;
        if (sh < -80'sd2147483648) return 32'h8000_0000;
`endif
        return sh[31:0];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NW; i++) wmem[i] = $signed($urandom) >>> $urandom_range(0, 24);
        for (int k = 0; k < K; k++)  vvec[k] = $signed($urandom) >>> $urandom_range(0, 20);
    endtask

    task automatic load_vec(output bit ok);
        int g;
        ok = 1'b1;
        for (int k = 0; k < K; k++) begin
            g = 0;
            while (!in_ready && g < 200) begin @(negedge clk); g++; end
            if (g >= 200) ok = 1'b0;
            in_valid = 1'b1;
            in_data  = vvec[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit rnd);
        int n;
        int cyc;
        bit hs;
        bit pv;
        n = 0; cyc = 0; pv = 1'b0; done_early = 0;
        for (int i = 0; i < OUT_LEN; i++) begin g_bias[i] = -100; g_rise[i] = -1; end
        while (n < OUT_LEN && cyc < 3000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) done_early++;
            if (w_rd_en && int'(w_addr) == n*(K+1)+K) g_bias[n] = cyc;
            if (out_valid && !pv) g_rise[n] = cyc;
            pv = out_valid;
            hs = out_valid && out_ready;
            if (hs) begin g_data[n] = out_data; g_idx[n] = out_idx; g_cyc[n] = cyc; end
            @(negedge clk);
            cyc++;
            if (hs) begin g_en[n] = w_rd_en; g_addr[n] = w_addr; n++; end
        end
        timed_out = (n < OUT_LEN);
        done_end  = done;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, w_rd_en, out_valid, busy, done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, w_rd_en, out_valid, busy, done});
        end
        checks++;
        if ({w_addr, out_data, out_idx} !== '0) begin
            errors++; $display("FAIL reset_data: got addr=%h data=%h idx=%h want 0", w_addr, out_data, out_idx);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_identity();
        bit ok;
        logic [31:0] exp;
        for (int r = 0; r < OUT_LEN; r++)
            for (int k = 0; k <= K; k++)
                wmem[r*(K+1)+k] = (k < K && k == r % 4) ? 32'sh0001_0000 : 32'sh0;
        for (int k = 0; k < K; k++) vvec[k] = 32'(k + 1) << 16;
        load_vec(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL identity_load: in_ready never seen"); end
        collect(1'b0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL identity_timeout: rows missing"); end
        for (int i = 0; i < OUT_LEN; i++) begin
            exp = 32'((i % 4) + 1) << 16;
            checks++;
            if (g_idx[i] !== 9'(i) || g_data[i] !== exp) begin
                errors++; $display("FAIL identity_row %0d: got idx=%0d data=%h want idx=%0d data=%h", i, g_idx[i], g_data[i], i, exp);
            end
            checks++;
            if (g_rise[i] - g_bias[i] != 2) begin
                errors++; $display("FAIL identity_latency row %0d: got %0d want 2", i, g_rise[i] - g_bias[i]);
            end
            if (i > 0) begin
                checks++;
                if (g_cyc[i] - g_cyc[i-1] != int'(K + 3)) begin
                    errors++; $display("FAIL identity_period row %0d: got %0d want %0d", i, g_cyc[i] - g_cyc[i-1], K + 3);
                end
            end
            if (i < OUT_LEN - 1) begin
                checks++;
                if (g_en[i] !== 1'b1 || int'(g_addr[i]) != (i + 1) * (K + 1)) begin
                    errors++; $display("FAIL identity_next_read row %0d: got en=%b addr=%0d want 1 %0d", i, g_en[i], g_addr[i], (i + 1) * (K + 1));
                end
            end
        end
        checks++;
        if (done_end !== 1'b1 || done_early != 0) begin
            errors++; $display("FAIL identity_done: got end=%b early=%0d want 1 0", done_end, done_early);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL identity_idle: got done=%b busy=%b in_ready=%b want 0 0 1", done, busy, in_ready);
        end
    endtask

    task automatic test_bias_neg();
        bit ok;
        int bad;
        for (int r = 0; r < OUT_LEN; r++)
            for (int k = 0; k <= K; k++)
                wmem[r*(K+1)+k] = (k < K) ? 32'sh0000_8000 : 32'sh0000_4000;
        for (int k = 0; k < K; k++) vvec[k] = 32'shFFFF_0000;
        load_vec(ok);
        collect(1'b1);
        checks++;
        if (!ok || timed_out) begin errors++; $display("FAIL bias_timeout: got ok=%b timeout=%b want 1 0", ok, timed_out); end
        bad = 0;
        for (int i = 0; i < OUT_LEN; i++) begin
            checks++;
            if (g_data[i] !== 32'hFFFE_4000 || g_idx[i] !== 9'(i)) begin
                errors++; bad++;
                $display("FAIL bias_row %0d: got idx=%0d data=%h want idx=%0d data=fffe4000", i, g_idx[i], g_data[i], i);
            end
        end
        checks++;
        if (done_end !== 1'b1) begin errors++; $display("FAIL bias_done: got %b want 1", done_end); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit hs;
        int n;
        int cyc;
        int hold;
        logic [31:0] sd;
        logic [8:0]  si;
        fill_random();
        load_vec(ok);
        n = 0; cyc = 0; hold = 0; sd = '0; si = '0;
        while (n < OUT_LEN && cyc < 3000) begin
            if (out_valid && out_idx == 9'd3 && hold < 5) begin
                out_ready = 1'b0;
                if (hold == 0) begin
                    sd = out_data; si = out_idx;
                end else begin
                    checks++;
                    if (out_data !== sd || out_idx !== si) begin
                        errors++; $display("FAIL bp_stable: got data=%h idx=%0d want data=%h idx=%0d", out_data, out_idx, sd, si);
                    end
                end
                checks++;
                if (w_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b want 0", w_rd_en); end
                hold++;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            hs = out_valid && out_ready;
            if (hs) begin
                checks++;
                if (out_data !== ref_z(n) || out_idx !== 9'(n)) begin
                    errors++; $display("FAIL bp_row %0d: got idx=%0d data=%h want idx=%0d data=%h", n, out_idx, out_data, n, ref_z(n));
                end
            end
            if (busy && in_ready !== 1'b0) begin
                checks++; errors++; $display("FAIL bp_in_ready: got 1 want 0");
            end
            @(negedge clk);
            cyc++;
            if (hs) begin
                n++;
                if (n == 4) begin
                    checks++;
                    if (w_rd_en !== 1'b1 || int'(w_addr) != 4 * (K + 1)) begin
                        errors++; $display("FAIL bp_row4_read: got en=%b addr=%0d want 1 %0d", w_rd_en, w_addr, 4 * (K + 1));
                    end
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!ok || n < OUT_LEN || hold != 5 || done !== 1'b1) begin
            errors++; $display("FAIL bp_complete: got rows=%0d hold=%0d done=%b want %0d 5 1", n, hold, done, OUT_LEN);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [31:0] exp;
`ifdef LSTM_GATE_MAC_SAT_EN
        exp = 32'h7FFF_FFFF;
`else
        exp = 32'h0004_0000;
`endif
        for (int r = 0; r < OUT_LEN; r++)
            for (int k = 0; k <= K; k++)
                wmem[r*(K+1)+k] = (k < K) ? 32'sh7FFF_0000 : 32'sh0;
        for (int k = 0; k < K; k++) vvec[k] = 32'sh7FFF_0000;
        load_vec(ok);
        collect(1'b0);
        checks++;
        if (!ok || timed_out) begin errors++; $display("FAIL sat_timeout: got ok=%b timeout=%b want 1 0", ok, timed_out); end
        for (int i = 0; i < OUT_LEN; i += 3) begin
            checks++;
            if (g_data[i] !== exp) begin
                errors++; $display("FAIL sat_row %0d: got %h want %h", i, g_data[i], exp);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int v = 0; v < 4; v++) begin
            fill_random();
            load_vec(ok);
            collect(1'b1);
            checks++;
            if (!ok || timed_out || done_end !== 1'b1 || done_early != 0) begin
                errors++; $display("FAIL rand_flow vec %0d: got ok=%b timeout=%b done=%b early=%0d", v, ok, timed_out, done_end, done_early);
            end
            for (int i = 0; i < OUT_LEN; i++) begin
                checks++;
                if (g_data[i] !== ref_z(i) || g_idx[i] !== 9'(i)) begin
                    errors++; $display("FAIL rand_row v%0d r%0d: got idx=%0d data=%h want idx=%0d data=%h", v, i, g_idx[i], g_data[i], i, ref_z(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        fill_random();
        load_vec(ok);
        collect(1'b0);
        checks++;
        if (done_end !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_handover: got done=%b in_ready=%b want 1 1", done_end, in_ready);
        end
        fill_random();
        load_vec(ok);
        collect(1'b0);
        checks++;
        if (!ok || timed_out || done_early != 0) begin
            errors++; $display("FAIL b2b_flow: got ok=%b timeout=%b early=%0d want 1 0 0", ok, timed_out, done_early);
        end
        for (int i = 0; i < OUT_LEN; i++) begin
            checks++;
            if (g_data[i] !== ref_z(i) || g_idx[i] !== 9'(i)) begin
                errors++; $display("FAIL b2b_row %0d: got idx=%0d data=%h want idx=%0d data=%h", i, g_idx[i], g_data[i], i, ref_z(i));
            end
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        int dcount;
        fill_random();
        load_vec(ok);
        repeat (3) @(negedge clk);
        checks++;
        if (w_rd_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL midrst_in_mac: got en=%b busy=%b want 1 1", w_rd_en, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, w_rd_en, out_valid, busy, done, w_addr, out_data, out_idx} !== '0) begin
            errors++; $display("FAIL midrst_outputs: got ready=%b en=%b valid=%b busy=%b done=%b addr=%h want all 0",
                               in_ready, w_rd_en, out_valid, busy, done, w_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || out_valid || busy) dcount++;
        end
        checks++;
        if (dcount != 0) begin errors++; $display("FAIL midrst_abandon: got %0d active cycles want 0", dcount); end
        fill_random();
        load_vec(ok);
        collect(1'b1);
        checks++;
        if (!ok || timed_out || done_early != 0 || done_end !== 1'b1) begin
            errors++; $display("FAIL midrst_reload: got ok=%b timeout=%b early=%0d done=%b", ok, timed_out, done_early, done_end);
        end
        for (int i = 0; i < OUT_LEN; i++) begin
            checks++;
            if (g_data[i] !== ref_z(i)) begin
                errors++; $display("FAIL midrst_row %0d: got %h want %h", i, g_data[i], ref_z(i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) wmem[i] = '0;
        test_reset();
        test_identity();
        test_bias_neg();
        test_backpressure();
        test_saturation();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lstm_gate_mac.md
Name: lstm_gate_mac

Overview:
- Upstream pre-activation engine for the LSTM cell stage.
- Computes z[r] = sum_k W[r][k]*v[k] + b[r] for all 4*HID gate rows; v = {x_t, h_prev} and gate order is f, g, i, o.
- Streams each z[r] with its row index; the downstream collector assembles the fgio_in array consumed by the gate/state-update stage.
- One signed 32x32 multiplier, sequential, with weights and bias read from an external synchronous memory.

Parameters:
- IN_LEN, 100, length of x_t.
- HID, 100, hidden size, i.e. length of h_prev; OUT_LEN = 4*HID rows.
- FRAC_BITS, 16, fractional bits of the signed Q format used for all data and weights.
- WADDR_W, 17, weight memory address width; must satisfy 2^WADDR_W >= OUT_LEN*(IN_LEN+HID+1).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, block accepts an input word.
- in_data, in, 32 signed, v[k]: x_t words first, then h_prev words.
- w_rd_en, out, 1, weight memory read strobe.
- w_addr, out, WADDR_W, weight memory address.
- w_rd_data, in, 32 signed, weight memory data, valid one cycle after w_rd_en.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_data, out, 32 signed, z[r].
- out_idx, out, 9, row index r.
- busy, out, 1, high whenever the block is not in IDLE.
- done, out, 1, one-cycle pulse after row OUT_LEN-1 is accepted.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. On rst, all outputs go to 0, state goes to IDLE, and all counters and the accumulator clear. Reset mid-operation abandons the vector with no output and no done.
- Widths: K = IN_LEN+HID. The vector buffer holds K x 32-bit words. Weight layout is row-major with stride K+1: W[r][k] at r*(K+1)+k, and b[r] at r*(K+1)+K. Addresses are produced by an incrementing counter, not a multiplier.
- IDLE: in_ready=1. The first accepted word (in_valid & in_ready) is stored at k=0 and moves the FSM to LOAD.
- LOAD: in_ready=1. Words fill k=1..K-1. Acceptance of word K-1 moves the FSM to MAC with r=0, k=0, acc=0.
- MAC:
  - in_ready=0; in_valid is ignored.
  - w_rd_en=1 for K+1 consecutive cycles, with addresses r*(K+1)+0 .. r*(K+1)+K.
  - Cycle after a read for k<K: acc += W*v[k], using the full 64-bit product.
  - Cycle after the bias read: acc += sign_extend(b) << FRAC_BITS, then go to RESULT.
  - Accumulator width is 64+clog2(K+1) bits and must never overflow internally.
- RESULT: out_data = saturate_or_wrap(acc >>> FRAC_BITS), using an arithmetic shift (truncation toward minus infinity). out_idx=r and out_valid=1.
- Latency: out_valid rises 2 cycles after the bias read is issued.
- OUT:
  - out_valid, out_data and out_idx are held stable until out_ready; w_rd_en=0 while waiting.
  - On handshake with r<OUT_LEN-1: r++, acc=0, and the next row's first read is issued the following cycle.
  - On handshake with r=OUT_LEN-1: done=1 for the next cycle, then IDLE.
  - out_valid may be asserted with out_ready already high, giving a one-cycle handshake.
- Per-row throughput with out_ready tied high: K+3 cycles.
- busy is 0 only in IDLE. in_ready is exactly (state==IDLE || state==LOAD).

Optional Feature:
- Macro: LSTM_GATE_MAC_SAT_EN.
- Defined: results above 0x7FFFFFFF clamp to 0x7FFFFFFF, and results below 0x80000000 clamp to 0x80000000.
- Undefined: out_data takes the low 32 bits of the shifted accumulator (two's-complement wrap), and the clamp logic is removed.

Test Plan:
- Reset: assert rst asynchronously mid-cycle during MAC -> all outputs 0 immediately. After release, a new vector loads from k=0 and no done pulse appears for the abandoned vector.
- Identity: IN_LEN=2, HID=2; v = 0x00010000, 0x00020000, 0x00030000, 0x00040000; W[r][k] = 0x00010000 if k==r%4 else 0; b=0. Required result: out_idx 0..7 with out_data 1.0, 2.0, 3.0, 4.0, 1.0, 2.0, 3.0, 4.0; done one cycle after idx 7. With out_ready high, each row takes 7 cycles.
- Bias/negatives: all W = 0x00008000 (0.5); v all 0xFFFF0000 (-1.0); b = 0x00004000 (0.25). Every row gives 0xFFFE4000 (-1.75).
- Backpressure: hold out_ready=0 for 5 cycles on row 3. Required: out_data/out_idx stable, w_rd_en=0, and row 4 reads start the cycle after the handshake. Toggling in_valid during MAC has no effect.
- Saturation: all W and v = 0x7FFF0000, b=0. With LSTM_GATE_MAC_SAT_EN defined, out_data = 0x7FFFFFFF; undefined, out_data = 0x00040000.
- Back-to-back: start a second vector while done is high -> in_ready=1 in IDLE, and the second result set is correct with no data carried over from the first.
